fp_32_to_16_convert_pipe: RTL and testbench
===========================================

// Module: fp_32_to_16_convert_pipe
// PURPOSE
// - Pipelined FP32 -> FP16 down-converter with valid/ready handshake; inverse direction of the FP16->FP32 widening
//   path that feeds the FP32 accumulator.
// - Narrows accumulated FP32 results back to FP16 for write-out; IEEE-754 round-to-nearest-even, per-result flags.
// PARAMETERS
// - QNAN_FP16   16'h7E00  canonical quiet NaN emitted for any NaN input (sign ignored)
// PORTS
// - clk_i         in   1   clock, all state on rising edge
// - rst_i         in   1   asynchronous, active-high reset
// - valid_i       in   1   operand_fp32_i valid
// - ready_o       out  1   block accepts operand this cycle
// - operand_fp32_i in  32  FP32 input {s,e[7:0],m[22:0]}
// - valid_o       out  1   result_o valid
// - ready_i       in   1   downstream accepts result this cycle
// - result_fp16_o out  16  FP16 result {s,e[4:0],m[9:0]}
// - overflow_o    out  1   finite input rounded to +/-inf
// - underflow_o   out  1   result tiny (subnormal or zero from nonzero) and inexact
// - inexact_o     out  1   any discarded nonzero bit
// BEHAVIOUR
// - Reset: both stage valids=0; valid_o=0, result_fp16_o=16'h0000, all flags=0. Async assert, sync-safe deassert.
// - Pipeline: 2 stages, global enable en = ~valid_o | ready_i; ready_o = en. On en both stages advance together;
//   latency exactly 2 cycles with ready_i=1; throughput 1/cycle.
// - Stall: while valid_o & ~ready_i, result_fp16_o/flags/valid_o held stable, ready_o=0, no input consumed.
// - Bubbles propagate as valid=0; data regs may update on bubbles, outputs only meaningful with valid_o.
// - Stage 1: unpack, classify (zero, fp32-subnormal, normal, inf, NaN), E = e-127, align mantissa, form
//   10-bit mant, guard G, sticky S.
//   - Normal range E in [-14,15]: exp16=E+15, mant=m[22:13], G=m[12], S=|m[11:0].
//   - E>15: overflow -> {s,5'h1F,10'h0}, overflow=1, inexact=1.
//   - E in [-25,-15]: subnormal path, shift {1,m} right by (-14-E), exp16=0, G/S from shifted-out bits.
//   - E<-25 or fp32 subnormal: signed zero, inexact=underflow=|(input mag).
//   - zero -> {s,15'h0}; inf -> {s,5'h1F,10'h0}; NaN -> QNAN_FP16; no flags for zero/inf/NaN.
// - Stage 2: RNE increment if G & (S | mant[0]); mantissa carry bumps exponent (subnormal 0x3FF+1 -> min normal
//   0x0400 allowed); exp reaching 31 after rounding -> inf with overflow=1. inexact = G|S.
// - Signed zero preserved; sign always passed except NaN.
// - Reset mid-operation: in-flight data discarded, valid_o drops same cycle asynchronously.
// CONFIGURATION
// - FP_32_16_SUBNORMAL_EN defined: subnormal path above; results in [2^-25, 2^-14) yield FP16 subnormals.
// - Not defined: any input with E<-14 (pre-round) flushes to {s,15'h0}, underflow=1, inexact=1; subnormal shifter
//   removed from stage 1.
// TESTING
// - 0x3F800000 (1.0) -> 0x3C00, no flags, valid_o exactly 2 cycles after accept.
// - 0x477FE000 (65504) -> 0x7BFF no flags; 0x477FF000 (65520) -> 0x7C00, overflow=1, inexact=1.
// - Ties: 0x3F801000 -> 0x3C00 (tie to even), inexact=1; 0x3F803000 -> 0x3C02, inexact=1.
// - 0x33800000 (2^-24) -> 0x0001 with FP_32_16_SUBNORMAL_EN, no flags; -> 0x0000, underflow=inexact=1 without.
// - Specials: 0xFF800000 -> 0xFC00; 0x7FC00001 -> 0x7E00; 0x80000000 -> 0x8000; all flags 0.
// - Backpressure: stream 4 values with ready_i=0 for 3 cycles mid-stream -> ready_o=0 while stalled, outputs
//   held, all 4 results delivered in order, none lost or duplicated.
// - Assert rst_i with 2 items in flight -> valid_o=0 immediately; after release first new input emerges
//   2 cycles after accept.

Source files
------------

// File: rtl/fp_32_to_16_convert_pipe.sv
// Two-stage FP32 -> FP16 down-converter (round-to-nearest-even) with valid/ready handshake.
// Define FP_32_16_SUBNORMAL_EN to produce FP16 subnormals; otherwise tiny results flush to signed zero.
module fp_32_to_16_convert_pipe #(
    parameter logic [15:0] QNAN_FP16 = 16'h7E00
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] operand_fp32_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [15:0] result_fp16_o,
    output logic        overflow_o,
    output logic        underflow_o,
    output logic        inexact_o
);

    // NOTE: one global enable stalls both stages together, so ready_o is combinational from valid_o/ready_i.
    logic en;
    assign en      = ~valid_o | ready_i;
    assign ready_o = en;

    // ---------------- stage 1: unpack, classify, align ----------------
    logic              in_sign;
    logic [7:0]        in_exp;
    logic [22:0]       in_man;
    logic signed [9:0] unb_exp;

    assign in_sign = operand_fp32_i[31];
    assign in_exp  = operand_fp32_i[30:23];
    assign in_man  = operand_fp32_i[22:0];
    assign unb_exp = $signed({2'b00, in_exp}) - 10'sd127;

    logic        c_fixed;
    logic [15:0] c_fixed_res;
    logic [2:0]  c_fixed_flags;   // {overflow, underflow, inexact}
    logic [4:0]  c_exp;
    logic [9:0]  c_mant;
    logic        c_g;
    logic        c_s;

`ifdef FP_32_16_SUBNORMAL_EN
    logic [3:0]  sub_shift;
    logic [33:0] sub_aligned;
    // Hidden-one mantissa parked so that an unshifted value already sits at the E=-15 subnormal position.
    assign sub_shift   = 4'(-10'sd15 - unb_exp);
    assign sub_aligned = {1'b1, in_man, 10'b0} >> sub_shift;
`endif

    always_comb begin
        c_fixed       = 1'b0;
        c_fixed_res   = 16'h0000;
        c_fixed_flags = 3'b000;
        c_exp         = 5'd0;
        c_mant        = 10'd0;
        c_g           = 1'b0;
        c_s           = 1'b0;
        if (in_exp == 8'hFF) begin
            c_fixed     = 1'b1;
            c_fixed_res = (in_man != 23'd0) ? QNAN_FP16 : {in_sign, 5'h1F, 10'h000};
        end else if (in_exp == 8'h00) begin
            c_fixed       = 1'b1;
            c_fixed_res   = {in_sign, 15'h0000};
            c_fixed_flags = {1'b0, |in_man, |in_man};
        end else if (unb_exp > 10'sd15) begin
            c_fixed       = 1'b1;
            c_fixed_res   = {in_sign, 5'h1F, 10'h000};
            c_fixed_flags = 3'b101;
        end else if (unb_exp >= -10'sd14) begin
            c_exp  = 5'(unb_exp + 10'sd15);
            c_mant = in_man[22:13];
            c_g    = in_man[12];
            c_s    = |in_man[11:0];
`ifdef FP_32_16_SUBNORMAL_EN
        end else if (unb_exp >= -10'sd25) begin
            c_mant = sub_aligned[33:24];
            c_g    = sub_aligned[23];
            c_s    = |sub_aligned[22:0];
`endif
        end else begin
            c_fixed       = 1'b1;
            c_fixed_res   = {in_sign, 15'h0000};
            c_fixed_flags = 3'b011;
        end
    end

    logic        s1_valid;
    logic        s1_fixed;
    logic [15:0] s1_fixed_res;
    logic [2:0]  s1_fixed_flags;
    logic        s1_sign;
    logic [4:0]  s1_exp;
    logic [9:0]  s1_mant;
    logic        s1_g;
    logic        s1_s;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid       <= 1'b0;
            s1_fixed       <= 1'b0;
            s1_fixed_res   <= 16'h0000;
            s1_fixed_flags <= 3'b000;
            s1_sign        <= 1'b0;
            s1_exp         <= 5'd0;
            s1_mant        <= 10'd0;
            s1_g           <= 1'b0;
            s1_s           <= 1'b0;
        end else if (en) begin
            s1_valid       <= valid_i;
            s1_fixed       <= c_fixed;
            s1_fixed_res   <= c_fixed_res;
            s1_fixed_flags <= c_fixed_flags;
            s1_sign        <= in_sign;
            s1_exp         <= c_exp;
            s1_mant        <= c_mant;
            s1_g           <= c_g;
            s1_s           <= c_s;
        end
    end

    // ---------------- stage 2: round to nearest even, pack ----------------
    logic        rnd_inc;
    logic [14:0] rnd_sum;
    logic        rnd_ovf;
    logic        rnd_inx;
    logic        rnd_unf;

    // Carry out of the mantissa lands in the exponent field, which covers both
    // subnormal -> min-normal and max-normal -> infinity.
    assign rnd_inc = s1_g & (s1_s | s1_mant[0]);
    assign rnd_sum = {s1_exp, s1_mant} + 15'(rnd_inc);
    assign rnd_ovf = &rnd_sum[14:10];
    assign rnd_inx = s1_g | s1_s;
    assign rnd_unf = rnd_inx & (rnd_sum[14:10] == 5'd0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o       <= 1'b0;
            result_fp16_o <= 16'h0000;
            overflow_o    <= 1'b0;
            underflow_o   <= 1'b0;
            inexact_o     <= 1'b0;
        end else if (en) begin
            valid_o <= s1_valid;
            if (s1_fixed) begin
                result_fp16_o <= s1_fixed_res;
                overflow_o    <= s1_fixed_flags[2];
                underflow_o   <= s1_fixed_flags[1];
                inexact_o     <= s1_fixed_flags[0];
            end else begin
                result_fp16_o <= {s1_sign, rnd_sum};
                overflow_o    <= rnd_ovf;
                underflow_o   <= rnd_unf;
                inexact_o     <= rnd_inx;
            end
        end
    end

endmodule

// File: tb/tb_fp_32_to_16_convert_pipe.sv
// Directed-vector bench for fp_32_to_16_convert_pipe: conversion table, backpressure stream, mid-flight reset.
// Expectations follow FP_32_16_SUBNORMAL_EN when it is defined for the build.
module tb_fp_32_to_16_convert_pipe;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] operand_fp32_i;
    logic        valid_o;
    logic        ready_i;
    logic [15:0] result_fp16_o;
    logic        overflow_o;
    logic        underflow_o;
    logic        inexact_o;

    fp_32_to_16_convert_pipe dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .operand_fp32_i (operand_fp32_i),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .result_fp16_o  (result_fp16_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o),
        .inexact_o      (inexact_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [31:0] op;
        logic [15:0] res;
        logic [2:0]  flags;   // {overflow, underflow, inexact}
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents one operand with ready_i=1 and counts rising edges until valid_o appears (bounded).
    task automatic send_one(input logic [31:0] op, output int lat);
        ready_i        = 1'b1;
        valid_i        = 1'b1;
        operand_fp32_i = op;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        lat     = 1;
        while (!valid_o && lat < 10) begin
            @(posedge clk_i); #1;
            lat++;
        end
    endtask

    function automatic vec_t mk(input string n, input logic [31:0] op, input logic [15:0] res, input logic [2:0] fl);
        vec_t v;
        v.name = n; v.op = op; v.res = res; v.flags = fl;
        return v;
    endfunction

    vec_t        vecs[$];
    logic [31:0] stream_in[4];
    logic [15:0] stream_exp[4];
    logic [15:0] got[$];

    initial begin
        int          lat;
        int          idx;
        int          stalls;
        logic        was_stall;
        logic        accepted;
        logic [19:0] snap;

        vecs.push_back(mk("one",        32'h3F800000, 16'h3C00, 3'b000));
        vecs.push_back(mk("max_fp16",   32'h477FE000, 16'h7BFF, 3'b000));
        vecs.push_back(mk("rnd_to_inf", 32'h477FF000, 16'h7C00, 3'b101));
        vecs.push_back(mk("tie_even",   32'h3F801000, 16'h3C00, 3'b001));
        vecs.push_back(mk("tie_up",     32'h3F803000, 16'h3C02, 3'b001));
        vecs.push_back(mk("neg_inf",    32'hFF800000, 16'hFC00, 3'b000));
        vecs.push_back(mk("nan",        32'h7FC00001, 16'h7E00, 3'b000));
        vecs.push_back(mk("neg_zero",   32'h80000000, 16'h8000, 3'b000));
        vecs.push_back(mk("pos_inf",    32'h7F800000, 16'h7C00, 3'b000));
        vecs.push_back(mk("two",        32'h40000000, 16'h4000, 3'b000));
        vecs.push_back(mk("neg_1p5",    32'hBFC00000, 16'hBE00, 3'b000));
        vecs.push_back(mk("tenth",      32'h3DCCCCCD, 16'h2E66, 3'b001));
        vecs.push_back(mk("max_fp32",   32'h7F7FFFFF, 16'h7C00, 3'b101));
        vecs.push_back(mk("fp32_sub",   32'h80000001, 16'h8000, 3'b011));
        vecs.push_back(mk("fp32_minn",  32'h00800000, 16'h0000, 3'b011));
        vecs.push_back(mk("min_norm",   32'h38800000, 16'h0400, 3'b000));
        vecs.push_back(mk("two_m26",    32'h32800000, 16'h0000, 3'b011));
`ifdef FP_32_16_SUBNORMAL_EN
        vecs.push_back(mk("two_m24",    32'h33800000, 16'h0001, 3'b000));
        vecs.push_back(mk("two_m15",    32'h38000000, 16'h0200, 3'b000));
        vecs.push_back(mk("sub_tie_up", 32'h33C00000, 16'h0002, 3'b011));
        vecs.push_back(mk("two_m25",    32'h33000000, 16'h0000, 3'b011));
`else
        vecs.push_back(mk("two_m24",    32'h33800000, 16'h0000, 3'b011));
        vecs.push_back(mk("two_m15",    32'h38000000, 16'h0000, 3'b011));
        vecs.push_back(mk("sub_tie_up", 32'h33C00000, 16'h0000, 3'b011));
`endif

        stream_in  = '{32'h3F800000, 32'h40000000, 32'hBFC00000, 32'h3DCCCCCD};
        stream_exp = '{16'h3C00, 16'h4000, 16'hBE00, 16'h2E66};

        // Reset state
        rst_i          = 1'b1;
        valid_i        = 1'b0;
        ready_i        = 1'b1;
        operand_fp32_i = 32'h0;
        #1;
        check("rst_valid",  32'(valid_o), 32'd0);
        check("rst_result", 32'(result_fp16_o), 32'h0);
        check("rst_flags",  32'({overflow_o, underflow_o, inexact_o}), 32'd0);
        check("rst_ready",  32'(ready_o), 32'd1);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Conversion table, one operand at a time
        for (int i = 0; i < vecs.size(); i++) begin
            send_one(vecs[i].op, lat);
            check({vecs[i].name, "_lat"},   32'(lat), 32'd2);
            check({vecs[i].name, "_res"},   32'(result_fp16_o), 32'(vecs[i].res));
            check({vecs[i].name, "_flags"}, 32'({overflow_o, underflow_o, inexact_o}), 32'(vecs[i].flags));
        end
        repeat (2) @(posedge clk_i);
        #1;

        // Backpressure: ready_i low for cycles 3..5 of a 4-item stream
        idx       = 0;
        stalls    = 0;
        was_stall = 1'b0;
        snap      = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            ready_i        = !(cyc >= 3 && cyc < 6);
            valid_i        = (idx < 4);
            operand_fp32_i = (idx < 4) ? stream_in[idx] : 32'h0;
            #1;
            if (was_stall)
                check("stall_hold", 32'({valid_o, result_fp16_o, overflow_o, underflow_o, inexact_o}), 32'(snap));
            accepted = valid_i & ready_o;
            if (valid_o && !ready_i) begin
                stalls++;
                check("stall_ready", 32'(ready_o), 32'd0);
                snap      = {valid_o, result_fp16_o, overflow_o, underflow_o, inexact_o};
                was_stall = 1'b1;
            end else begin
                was_stall = 1'b0;
            end
            if (valid_o && ready_i)
                got.push_back(result_fp16_o);
            @(posedge clk_i); #1;
            if (accepted)
                idx++;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        check("stall_cycles", 32'(stalls), 32'd3);
        check("stream_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < got.size())
                check($sformatf("stream_%0d", i), 32'(got[i]), 32'(stream_exp[i]));

        // Reset with two items in flight
        ready_i        = 1'b1;
        valid_i        = 1'b1;
        operand_fp32_i = 32'h3F800000;
        @(posedge clk_i); #1;
        operand_fp32_i = 32'hBFC00000;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        check("pre_rst_valid", 32'(valid_o), 32'd1);
        #1;
        rst_i = 1'b1;
        #1;
        check("rst_async_valid", 32'(valid_o), 32'd0);
        check("rst_async_res",   32'(result_fp16_o), 32'h0);
        @(posedge clk_i); #1;
        check("rst_hold_valid", 32'(valid_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        send_one(32'h40000000, lat);
        check("post_rst_lat", 32'(lat), 32'd2);
        check("post_rst_res", 32'(result_fp16_o), 32'h4000);
        @(posedge clk_i); #1;
        check("post_rst_drain", 32'(valid_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
